// File: rtl/bit_population_counter_pipe.sv
// Pipelined, packet-aware population counter.
// A registered adder tree counts ones (or zeros) per beat. An accumulate stage
// sums the per-beat counts over a packet ending in last_i. One global enable,
// driven by the output handshake, stalls every stage at once.
module bit_population_counter_pipe #(
  parameter int WIDTH     = 16,
  parameter int CHUNK     = 4,
  parameter int MAX_BEATS = 4,
  localparam int CNT_W    = $clog2(WIDTH * MAX_BEATS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             mode_i,
  input  logic             last_i,
  input  logic             data_val_i,
  output logic             data_ready_o,
  output logic [CNT_W-1:0] data_o,
  output logic             err_o,
  output logic             data_val_o,
  input  logic             data_ready_i
);

  localparam int N      = WIDTH / CHUNK;
  localparam int LEVELS = $clog2(N);
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);

  // Node count at tree level k (level 0 = leaves).
  function automatic int nodes(input int k);
    return (N + (1 << k) - 1) >> k;
  endfunction

  // Count width at tree level k.
  function automatic int cw(input int k);
    return $clog2(CHUNK * (1 << k) + 1);
  endfunction

  // Bit offset of level k inside the flat tree bus.
  function automatic int offs(input int k);
    int o;
    o = 0;
    for (int i = 0; i < k; i++) o += nodes(i) * cw(i);
    return o;
  endfunction

  localparam int TREE_W  = offs(LEVELS + 1);
  localparam int TOP_W   = cw(LEVELS);
  localparam int TOP_OFF = offs(LEVELS);

  typedef enum logic {S_IDLE, S_ACC} state_e;

  logic              en;
  logic [TREE_W-1:0] tree;  // registered node values of every level, flattened

  // When en is low the output is held and nothing upstream may move.
  assign en           = !data_val_o || data_ready_i;
  assign data_ready_o = en;

  // ---------------------------------------------------------------------------
  // Adder tree: level 0 holds leaf counts, each later level pairwise sums.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    localparam int NK  = nodes(k);
    localparam int CW  = cw(k);
    localparam int OFF = offs(k);

    logic [NK-1:0][CW-1:0] cnt_d, cnt_q;

    if (k == 0) begin : g_leaf
      logic [WIDTH-1:0] word;
      // Leaf counts; counting zeros is counting ones of the inverted word.
      always_comb begin
        word = mode_i ? ~data_i : data_i;
        for (int j = 0; j < NK; j++)
          cnt_d[j] = CW'($countones(word[j*CHUNK +: CHUNK]));
      end
    end else begin : g_sum
      localparam int NP   = nodes(k - 1);
      localparam int PW   = cw(k - 1);
      localparam int POFF = offs(k - 1);

      logic [NP-1:0][PW-1:0] prev;
      assign prev = tree[POFF +: NP*PW];

      for (genvar j = 0; j < NK; j++) begin : g_node
        if (2*j + 1 < NP) begin : g_pair
          assign cnt_d[j] = CW'(prev[2*j]) + CW'(prev[2*j+1]);
        end else begin : g_pass
          // Odd node out is carried up unchanged.
          assign cnt_d[j] = CW'(prev[2*j]);
        end
      end
    end

    // Level register, frozen while stalled.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)  cnt_q <= '0;
      else if (en)   cnt_q <= cnt_d;
    end

    assign tree[OFF +: NK*CW] = cnt_q;
  end

  // ---------------------------------------------------------------------------
  // Valid / last side-band, one entry per tree level.
  // ---------------------------------------------------------------------------
  logic [LEVELS:0] vld_pipe_d, vld_pipe_q, last_pipe_d, last_pipe_q;

  // Shift valid and last alongside the tree data.
  always_comb begin
    vld_pipe_d     = vld_pipe_q;
    last_pipe_d    = last_pipe_q;
    vld_pipe_d[0]  = data_val_i;
    last_pipe_d[0] = last_i;
    for (int i = 1; i <= LEVELS; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
    end
  end

  // Side-band register; an accepted beat is exactly data_val_i while en.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else if (en) begin
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulate stage: packet sum, beat count, sticky overflow.
  // ---------------------------------------------------------------------------
  state_e             state_d, state_q;
  logic [CNT_W-1:0]   acc_d, acc_q, beat_cnt, acc_sum;
  logic [BEAT_W-1:0]  beats_d, beats_q;
  logic               sat_d, sat_q, ovf;
  logic               pkt_vld_d, pkt_vld_q, pkt_err_d, pkt_err_q;
  logic [CNT_W-1:0]   pkt_cnt_d, pkt_cnt_q;

  assign beat_cnt = CNT_W'(tree[TOP_OFF +: TOP_W]);
  assign acc_sum  = acc_q + beat_cnt;
  // A beat beyond MAX_BEATS, or any beat after one, saturates the packet.
  assign ovf      = sat_q || (beats_q == BEAT_W'(MAX_BEATS));

  // Next-state and packet-complete logic for the accumulator FSM.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    beats_d   = beats_q;
    sat_d     = sat_q;
    pkt_vld_d = 1'b0;
    pkt_cnt_d = pkt_cnt_q;
    pkt_err_d = pkt_err_q;
    if (vld_pipe_q[LEVELS]) begin
      case (state_q)
        S_IDLE: begin
          if (last_pipe_q[LEVELS]) begin
            pkt_vld_d = 1'b1;
            pkt_cnt_d = beat_cnt;
            pkt_err_d = 1'b0;
          end else begin
            acc_d   = beat_cnt;
            beats_d = BEAT_W'(1);
            state_d = S_ACC;
          end
        end
        S_ACC: begin
          if (last_pipe_q[LEVELS]) begin
            pkt_vld_d = 1'b1;
            pkt_cnt_d = ovf ? '1 : acc_sum;
            pkt_err_d = ovf;
            acc_d     = '0;
            beats_d   = '0;
            sat_d     = 1'b0;
            state_d   = S_IDLE;
          end else if (ovf) begin
            acc_d = '1;
            sat_d = 1'b1;
          end else begin
            acc_d   = acc_sum;
            beats_d = beats_q + BEAT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Accumulator and completed-packet registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      beats_q   <= '0;
      sat_q     <= 1'b0;
      pkt_vld_q <= 1'b0;
      pkt_cnt_q <= '0;
      pkt_err_q <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      beats_q   <= beats_d;
      sat_q     <= sat_d;
      pkt_vld_q <= pkt_vld_d;
      pkt_cnt_q <= pkt_cnt_d;
      pkt_err_q <= pkt_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] out_data_d, out_data_q;
  logic             out_err_d, out_err_q, out_vld_d, out_vld_q;

  // Load on packet completion; valid drops after a transfer with nothing new.
  always_comb begin
    out_vld_d  = pkt_vld_q;
    out_data_d = pkt_vld_q ? pkt_cnt_q : out_data_q;
    out_err_d  = pkt_vld_q ? pkt_err_q : out_err_q;
  end

  // Output holding register, frozen while the consumer back-pressures.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else if (en) begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

  assign data_o     = out_data_q;
  assign err_o      = out_err_q;
  assign data_val_o = out_vld_q;

endmodule

// File: tb/tb_bit_population_counter_pipe.sv
// Directed and randomised checks for bit_population_counter_pipe
// (WIDTH=16, CHUNK=4, MAX_BEATS=4 -> CNT_W=7, LAT=4).
module tb_bit_population_counter_pipe;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [15:0] data_i;
  logic        mode_i, last_i, data_val_i, data_ready_o;
  logic [6:0]  data_o;
  logic        err_o, data_val_o, data_ready_i;

  int n_chk  = 0;
  int n_pass = 0;

  bit_population_counter_pipe #(.WIDTH(16), .CHUNK(4), .MAX_BEATS(4)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .data_i       (data_i),
    .mode_i       (mode_i),
    .last_i       (last_i),
    .data_val_i   (data_val_i),
    .data_ready_o (data_ready_o),
    .data_o       (data_o),
    .err_o        (err_o),
    .data_val_o   (data_val_o),
    .data_ready_i (data_ready_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int d, input bit e);
    chk({tag, "_val"}, data_val_o, 1);
    chk({tag, "_data"}, data_o, d);
    chk({tag, "_err"}, err_o, e);
  endtask

  // Present one beat and hold it until the DUT accepts it.
  task automatic send(input logic [15:0] d, input logic m, input logic l);
    int guard;
    guard      = 0;
    data_i     = d;
    mode_i     = m;
    last_i     = l;
    data_val_i = 1'b1;
    while (!data_ready_o && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) chk("send_timeout", guard, 0);
    tick();
    data_val_i = 1'b0;
    last_i     = 1'b0;
  endtask

  logic [15:0] sv [4] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h00F3};
  int          se [4] = '{0, 1, 16, 6};
  logic [31:0] exp_q [$];
  logic [31:0] e;

  initial begin
    int sent, cyc, left, acc;
    bit took;
    rst_n_i = 1'b0; data_i = '0; mode_i = 1'b0; last_i = 1'b0;
    data_val_i = 1'b0; data_ready_i = 1'b1;
    #1;
    chk("in_reset_ready", data_ready_o, 1);
    chk("in_reset_val", data_val_o, 0);
    tick(); tick();
    rst_n_i = 1'b1;
    tick(); tick();
    chk("idle_val", data_val_o, 0);
    chk("idle_data", data_o, 0);
    chk("idle_err", err_o, 0);
    chk("idle_ready", data_ready_o, 1);

    // Single-beat packets with exact latency.
    for (int i = 0; i < 4; i++) begin
      send(sv[i], 1'b0, 1'b1);
      repeat (3) tick();
      chk("single_early", data_val_o, 0);
      tick();
      expect_out("single", se[i], 1'b0);
    end

    // Three-beat packet with a mode change, then a one-beat packet with no gap.
    send(16'hFFFF, 1'b0, 1'b0);
    send(16'h000F, 1'b1, 1'b0);
    send(16'h0101, 1'b0, 1'b1);
    send(16'h8000, 1'b0, 1'b1);
    repeat (3) tick();
    expect_out("pkt3", 30, 1'b0);
    tick();
    expect_out("pkt_b2b", 1, 1'b0);
    tick();
    chk("pkt_drain", data_val_o, 0);

    // Five beats overflow a four-beat budget; following packet is clean.
    repeat (4) send(16'hFFFF, 1'b0, 1'b0);
    send(16'hFFFF, 1'b0, 1'b1);
    send(16'h0003, 1'b0, 1'b1);
    repeat (3) tick();
    expect_out("ovf", 127, 1'b1);
    tick();
    expect_out("after_ovf", 2, 1'b0);
    tick();

    // Back-pressure: three results queue up behind a held output.
    data_ready_i = 1'b0;
    send(16'h0001, 1'b0, 1'b1);
    send(16'h0003, 1'b0, 1'b1);
    send(16'h0007, 1'b0, 1'b1);
    tick(); tick();
    chk("stall_ready", data_ready_o, 0);
    expect_out("stall_first", 1, 1'b0);
    repeat (5) tick();
    expect_out("stall_hold", 1, 1'b0);
    chk("stall_ready_hold", data_ready_o, 0);
    data_ready_i = 1'b1;
    #1;
    chk("release_ready", data_ready_o, 1);
    tick();
    expect_out("release_2", 2, 1'b0);
    tick();
    expect_out("release_3", 3, 1'b0);
    tick();
    chk("release_drain", data_val_o, 0);

    // Reset between beat 2 and beat 3 of a packet, with a result held.
    data_ready_i = 1'b0;
    send(16'h000F, 1'b0, 1'b1);
    send(16'hFFFF, 1'b0, 1'b0);
    send(16'hFFFF, 1'b0, 1'b0);
    tick(); tick();
    expect_out("pre_reset", 4, 1'b0);
    rst_n_i = 1'b0;
    #1;
    chk("rst_val", data_val_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ready", data_ready_o, 1);
    tick();
    rst_n_i = 1'b1;
    data_ready_i = 1'b1;
    send(16'h0007, 1'b0, 1'b1);
    repeat (3) tick();
    chk("post_rst_early", data_val_o, 0);
    tick();
    expect_out("post_rst", 3, 1'b0);
    tick();

    // Randomised packets of 1..4 beats under random back-pressure.
    sent = 0; cyc = 0; left = 0; acc = 0;
    while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      data_ready_i = ($urandom_range(0, 3) != 0);
      if (!data_val_i && sent < 1000 && $urandom_range(0, 4) != 0) begin
        if (left == 0) left = $urandom_range(1, 4);
        data_i     = 16'($urandom);
        mode_i     = 1'($urandom_range(0, 1));
        last_i     = (left == 1);
        data_val_i = 1'b1;
      end
      #1;
      if (data_val_o && data_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious", data_val_o, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_data", data_o, e[6:0]);
          chk("rnd_err", err_o, e[7]);
        end
      end
      took = 1'b0;
      if (data_val_i && data_ready_o) begin
        acc += mode_i ? (16 - $countones(data_i)) : $countones(data_i);
        left--;
        if (last_i) begin
          exp_q.push_back({25'd0, 7'(acc)});
          acc = 0;
          sent++;
        end
        took = 1'b1;
      end
      tick();
      cyc++;
      if (took) begin
        data_val_i = 1'b0;
        last_i     = 1'b0;
      end
    end
    chk("rnd_sent", sent, 1000);
    chk("rnd_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
